seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised, clocked successor to the combinational datapath ALU: registered result plus flags,
//  start/ready/done handshake, and a multi-cycle shift-add multiplier.
//  Sits between the register file read ports and the writeback mux.
//  The CPU sequencer issues one operation, waits for resultValid, then writes aluResult back.
// PARAMETERS
//  REGISTER_WIDTH  8  operand/result width in bits; legal range 2..32
//  OPCODE_WIDTH    4  opcode field width in bits; must hold every code in alu_pkg
// PORTS
//  clock           in   1               single system clock, rising edge
//  resetN          in   1               asynchronous, active-low reset
//  start           in   1               issue request; accepted only when ready=1
//  opCode          in   OPCODE_WIDTH    operation; sampled on acceptance
//  register1Value  in   REGISTER_WIDTH  operand A; sampled on acceptance
//  register2Value  in   REGISTER_WIDTH  operand B; sampled on acceptance
//  ready           out  1               block idle, can accept start
//  resultValid     out  1               one-cycle pulse: result and flags updated this cycle
//  aluResult       out  REGISTER_WIDTH  result (low half of product for MUL)
//  aluResultHigh   out  REGISTER_WIDTH  high half of product for MUL; 0 for all other ops
//  zeroFlag        out  1               aluResult == 0
//  carryFlag       out  1               carry/borrow/rotated-out bit (see below)
//  negativeFlag    out  1               aluResult[REGISTER_WIDTH-1]
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state=IDLE; ready=1; resultValid=0; aluResult=0; aluResultHigh=0.
//   - zeroFlag=1; carryFlag=0; negativeFlag=0.
//   - Reset mid-MUL aborts the operation with no resultValid.
//  FSM
//   - IDLE: start & ready & opCode!=MUL -> compute and register in one cycle.
//     resultValid=1 on the next cycle; stay IDLE.
//   - IDLE: start & opCode==MUL -> MUL_BUSY; ready=0; latch operands; count=0.
//   - MUL_BUSY: one shift-add step per cycle over REGISTER_WIDTH cycles.
//     Then -> IDLE with resultValid=1 and ready=1 in the same cycle.
//     Latency from acceptance = REGISTER_WIDTH+1 cycles.
//   - start while ready=0 is ignored: not queued, no effect.
//   - Back-to-back single-cycle ops are legal every cycle (throughput 1/cycle).
//   - aluResult and flags hold their value until the next resultValid.
//  Ops (W=REGISTER_WIDTH, all arithmetic modulo 2^W)
//   - ADD: A+B; carry = bit W of the W+1-bit sum.
//   - SUB: A-B; carry = borrow (A<B).
//   - INCREMENT: A+1; carry=1 iff A=all-ones.
//   - DECREMENT: A-1; carry=1 iff A=0.
//   - LSHIFT: rotate left {A[W-2:0],A[W-1]}; carry = A[W-1].
//   - RSHIFT: rotate right {A[0],A[W-1:1]}; carry = A[0].
//   - AND/OR/XOR: bitwise; carry=0.
//   - MUL: unsigned A*B as {aluResultHigh,aluResult}; carry = (aluResultHigh != 0).
//   - Undefined opcode: result 0, carry 0, resultValid still pulses (latency 1).
//  Flags
//   - zeroFlag and negativeFlag are computed on aluResult only, never on aluResultHigh.
// STRUCTURE
//  Package alu_pkg
//   - Opcode localparams: ADD=2, SUB=3, OR=6, XOR=7, AND=8, MUL=9, INCREMENT=11,
//     LSHIFT=13, DECREMENT=14, RSHIFT=15.
//   - FSM state enum {IDLE, MUL_BUSY}.
//  Sub-module alu_shift_add_mul: iterative multiplier.
//   - Ports: clock, resetN, load, multiplicand, multiplier, done, product[2W].
//  Top level: single-cycle ops as a combinational case, output/flag registers, FSM, counter.
// TESTING (REGISTER_WIDTH=8)
//  - Reset: resetN low -> ready=1, resultValid=0, aluResult=0, zeroFlag=1; hold through clock edges.
//  - ADD 0xF0+0x20 -> aluResult=0x10, carry=1, zero=0, neg=0.
//    SUB 0x05-0x06 -> 0xFF, carry=1, neg=1.
//  - INC 0xFF -> 0x00, carry=1, zero=1. DEC 0x00 -> 0xFF, carry=1.
//    LSHIFT 0x81 -> 0x03, carry=1. RSHIFT 0x01 -> 0x80, carry=1.
//  - MUL 0xFF*0xFF -> ready low 8 cycles, resultValid on cycle 9.
//    aluResult=0x01, aluResultHigh=0xFE, carry=1.
//    A second start during busy is ignored.
//  - Back-to-back AND 0xF0&0x3C, OR, XOR, opcode 0 on 4 consecutive cycles.
//    -> 0x30, 0xFC, 0xCC, 0x00; resultValid high 4 consecutive cycles.
//  - resetN pulsed low at MUL cycle 4 -> no resultValid; ready=1; outputs at reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (compared against the opCode input after a width cast)
//   - FSM state type, also exported on the top-level debug port
package alu_pkg;

  localparam int OP_ADD       = 2;
  localparam int OP_SUB       = 3;
  localparam int OP_OR        = 6;
  localparam int OP_XOR       = 7;
  localparam int OP_AND       = 8;
  localparam int OP_MUL       = 9;
  localparam int OP_INCREMENT = 11;
  localparam int OP_LSHIFT    = 13;
  localparam int OP_DECREMENT = 14;
  localparam int OP_RSHIFT    = 15;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: iterative unsigned shift-add multiplier, one step per cycle.
// Ports:
//   clock, resetN            clock, async active-low reset
//   load                     latch operands and begin (ignored meaning while busy is not used)
//   multiplicand, multiplier W-bit unsigned operands
//   done                     high during the cycle whose clock edge completes the last step
//   product                  2W-bit product, valid when done is high
// done and product are combinational from the final step so the caller can
// register the finished product on the same edge that performs that step.
module alu_shift_add_mul #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           resetN,
  input  logic           load,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic           r_busy;
  logic [CW-1:0]  r_count;
  logic [W-1:0]   r_mcand;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out LSB-first as the accumulator shifts in.
  logic [2*W-1:0] r_prod;

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_next;

  assign w_sum  = {1'b0, r_prod[2*W-1:W]} + {1'b0, (r_prod[0] ? r_mcand : {W{1'b0}})};
  assign w_next = {w_sum, r_prod[W-1:1]};

  assign done    = r_busy && (r_count == CW'(W - 1));
  assign product = w_next;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (load) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_mcand <= multiplicand;
      r_prod  <= {{W{1'b0}}, multiplier};
    end else if (r_busy) begin
      r_prod  <= w_next;
      r_count <= r_count + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with registered result/flags and a multi-cycle multiplier.
// Ports:
//   clock, resetN        clock, async active-low reset
//   start                issue request
//   opCode               operation (alu_pkg encodings)
//   register1Value (A), register2Value (B)  operands
//   ready                idle, can accept start
//   resultValid          one-cycle pulse when result/flags update
//   aluResult            result (low half of product for MUL)
//   aluResultHigh        high half of product for MUL, else 0
//   zeroFlag, carryFlag, negativeFlag  flags on aluResult
//   dbgState             current FSM state
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; opCode and operands are sampled on that edge. start while ready=0
// is dropped. Single-cycle ops pulse resultValid in the cycle after acceptance
// and may be issued every cycle. MUL drops ready for REGISTER_WIDTH cycles and
// raises ready together with resultValid. Results hold until the next pulse.
module seq_alu
  import alu_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8,
  parameter int OPCODE_WIDTH   = 4
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      start,
  input  logic [OPCODE_WIDTH-1:0]   opCode,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  input  logic [REGISTER_WIDTH-1:0] register2Value,
  output logic                      ready,
  output logic                      resultValid,
  output logic [REGISTER_WIDTH-1:0] aluResult,
  output logic [REGISTER_WIDTH-1:0] aluResultHigh,
  output logic                      zeroFlag,
  output logic                      carryFlag,
  output logic                      negativeFlag,
  output state_t                    dbgState
);

  localparam int W = REGISTER_WIDTH;

  state_t         r_state;
  logic           r_ready;
  logic           r_valid;
  logic [W-1:0]   r_result;
  logic [W-1:0]   r_result_high;
  logic           r_zero;
  logic           r_carry;
  logic           r_neg;

  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W-1:0]   w_res;
  logic           w_carry;
  logic           w_is_mul;
  logic           w_load;
  logic           w_mul_done;
  logic [2*W-1:0] w_product;
  logic [W-1:0]   w_mul_lo;
  logic [W-1:0]   w_mul_hi;

  assign w_a   = register1Value;
  assign w_b   = register2Value;
  // W+1-bit arithmetic: bit W is the carry (ADD) or borrow (SUB).
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (opCode)
      OPCODE_WIDTH'(OP_ADD):       begin w_res = w_add[W-1:0]; w_carry = w_add[W]; end
      OPCODE_WIDTH'(OP_SUB):       begin w_res = w_sub[W-1:0]; w_carry = w_sub[W]; end
      OPCODE_WIDTH'(OP_INCREMENT): begin w_res = w_a + 1'b1;   w_carry = &w_a;     end
      OPCODE_WIDTH'(OP_DECREMENT): begin w_res = w_a - 1'b1;   w_carry = ~|w_a;    end
      OPCODE_WIDTH'(OP_LSHIFT):    begin w_res = {w_a[W-2:0], w_a[W-1]}; w_carry = w_a[W-1]; end
      OPCODE_WIDTH'(OP_RSHIFT):    begin w_res = {w_a[0], w_a[W-1:1]};   w_carry = w_a[0];   end
      OPCODE_WIDTH'(OP_AND):       w_res = w_a & w_b;
      OPCODE_WIDTH'(OP_OR):        w_res = w_a | w_b;
      OPCODE_WIDTH'(OP_XOR):       w_res = w_a ^ w_b;
      default: ;
    endcase
  end

  assign w_is_mul = (opCode == OPCODE_WIDTH'(OP_MUL));
  assign w_load   = (r_state == IDLE) && start && w_is_mul;
  assign w_mul_lo = w_product[W-1:0];
  assign w_mul_hi = w_product[2*W-1:W];

  alu_shift_add_mul #(.W(W)) u_mul (
    .clock        (clock),
    .resetN       (resetN),
    .load         (w_load),
    .multiplicand (w_a),
    .multiplier   (w_b),
    .done         (w_mul_done),
    .product      (w_product)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_ready       <= 1'b1;
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_result_high <= '0;
      r_zero        <= 1'b1;
      r_carry       <= 1'b0;
      r_neg         <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_state <= MUL_BUSY;
              r_ready <= 1'b0;
            end else begin
              r_valid       <= 1'b1;
              r_result      <= w_res;
              r_result_high <= '0;
              r_carry       <= w_carry;
              r_zero        <= (w_res == '0);
              r_neg         <= w_res[W-1];
            end
          end
        end
        MUL_BUSY: begin
          if (w_mul_done) begin
            r_state       <= IDLE;
            r_ready       <= 1'b1;
            r_valid       <= 1'b1;
            r_result      <= w_mul_lo;
            r_result_high <= w_mul_hi;
            r_carry       <= (w_mul_hi != '0);
            r_zero        <= (w_mul_lo == '0);
            r_neg         <= w_mul_lo[W-1];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready         = r_ready;
  assign resultValid   = r_valid;
  assign aluResult     = r_result;
  assign aluResultHigh = r_result_high;
  assign zeroFlag      = r_zero;
  assign carryFlag     = r_carry;
  assign negativeFlag  = r_neg;
  assign dbgState      = r_state;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int OW = 4;
  localparam int EW = 2 * W + 3;  // {high, result, carry, zero, neg}

  logic          clock;
  logic          resetN;
  logic          start;
  logic [OW-1:0] opCode;
  logic [W-1:0]  register1Value;
  logic [W-1:0]  register2Value;
  logic          ready;
  logic          resultValid;
  logic [W-1:0]  aluResult;
  logic [W-1:0]  aluResultHigh;
  logic          zeroFlag;
  logic          carryFlag;
  logic          negativeFlag;
  state_t        dbgState;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  seq_alu #(.REGISTER_WIDTH(W), .OPCODE_WIDTH(OW)) dut (
    .clock          (clock),
    .resetN         (resetN),
    .start          (start),
    .opCode         (opCode),
    .register1Value (register1Value),
    .register2Value (register2Value),
    .ready          (ready),
    .resultValid    (resultValid),
    .aluResult      (aluResult),
    .aluResultHigh  (aluResultHigh),
    .zeroFlag       (zeroFlag),
    .carryFlag      (carryFlag),
    .negativeFlag   (negativeFlag),
    .dbgState       (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model straight from the operation definitions, plain integers.
  function automatic logic [EW-1:0] model(input int op, input int a, input int b);
    int m, r, hi, c, s;
    m = 1 << W; r = 0; hi = 0; c = 0;
    case (op)
      OP_ADD:       begin s = a + b; r = s % m; c = (s >= m) ? 1 : 0; end
      OP_SUB:       begin r = (a - b + m) % m; c = (a < b) ? 1 : 0; end
      OP_INCREMENT: begin r = (a + 1) % m; c = (a == m - 1) ? 1 : 0; end
      OP_DECREMENT: begin r = (a + m - 1) % m; c = (a == 0) ? 1 : 0; end
      OP_LSHIFT:    begin r = ((a * 2) % m) + (a / (m / 2)); c = a / (m / 2); end
      OP_RSHIFT:    begin r = (a / 2) + ((a % 2) * (m / 2)); c = a % 2; end
      OP_AND:       r = a & b;
      OP_OR:        r = a | b;
      OP_XOR:       r = a ^ b;
      OP_MUL:       begin s = a * b; r = s % m; hi = s / m; c = (hi != 0) ? 1 : 0; end
      default:      r = 0;
    endcase
    model = {hi[W-1:0], r[W-1:0], c[0], (r == 0), (r >= m / 2)};
  endfunction

  // Scoreboard: every resultValid pulse must match the oldest accepted op.
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (resetN === 1'b1 && resultValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(aluResult),     32'(e[EW-W-1 -: W]));
        check("high",   32'(aluResultHigh), 32'(e[EW-1 -: W]));
        check("carry",  32'(carryFlag),     32'(e[2]));
        check("zero",   32'(zeroFlag),      32'(e[1]));
        check("neg",    32'(negativeFlag),  32'(e[0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int op, input int a, input int b);
    start          = 1'b1;
    opCode         = op[OW-1:0];
    register1Value = a[W-1:0];
    register2Value = b[W-1:0];
  endtask

  // Single-cycle op issued from idle; result must appear on the next cycle.
  task automatic single_op(input int op, input int a, input int b);
    @(negedge clock);
    drive(op, a, b);
    exp_q.push_back(model(op, a, b));
    @(negedge clock);
    start = 1'b0;
    check("lat1_valid", 32'(resultValid), 32'd1);
    check("lat1_ready", 32'(ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_valid"}, 32'(resultValid), 32'd0);
    check({tag, "_res"},   32'(aluResult), 32'd0);
    check({tag, "_high"},  32'(aluResultHigh), 32'd0);
    check({tag, "_zero"},  32'(zeroFlag), 32'd1);
    check({tag, "_carry"}, 32'(carryFlag), 32'd0);
    check({tag, "_neg"},   32'(negativeFlag), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int bb_op[4];
    int op, a, b;
    int ops[11];

    resetN = 1'b0; start = 1'b0; opCode = '0;
    register1Value = '0; register2Value = '0;

    // Reset held through several edges, with start asserted to show it is ignored.
    repeat (2) @(negedge clock);
    drive(OP_ADD, 8'h11, 8'h22);
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    start = 1'b0;
    resetN = 1'b1;

    // Directed single-cycle cases.
    single_op(OP_ADD, 8'hF0, 8'h20);
    single_op(OP_SUB, 8'h05, 8'h06);
    single_op(OP_INCREMENT, 8'hFF, 8'h00);
    single_op(OP_DECREMENT, 8'h00, 8'h00);
    single_op(OP_LSHIFT, 8'h81, 8'h00);
    single_op(OP_RSHIFT, 8'h01, 8'h00);

    // MUL 0xFF*0xFF with an extra start during busy.
    @(negedge clock);
    drive(OP_MUL, 8'hFF, 8'hFF);
    exp_q.push_back(model(OP_MUL, 8'hFF, 8'hFF));
    @(negedge clock);
    cnt = 0;
    while (ready === 1'b0 && cnt < 20) begin
      cnt++;
      check("mul_busy_valid", 32'(resultValid), 32'd0);
      if (cnt == 1) drive(OP_ADD, 8'h01, 8'h01);
      if (cnt == 3) start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    check("mul_busy_cycles", 32'(cnt), 32'(W));
    check("mul_done_valid", 32'(resultValid), 32'd1);
    check("mul_done_ready", 32'(ready), 32'd1);

    // Back-to-back ops on consecutive cycles.
    bb_op[0] = OP_AND; bb_op[1] = OP_OR; bb_op[2] = OP_XOR; bb_op[3] = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i > 0) check("b2b_valid", 32'(resultValid), 32'd1);
      drive(bb_op[i], 8'hF0, 8'h3C);
      exp_q.push_back(model(bb_op[i], 8'hF0, 8'h3C));
    end
    @(negedge clock);
    check("b2b_valid", 32'(resultValid), 32'd1);
    start = 1'b0;
    @(negedge clock);
    check("b2b_idle", 32'(resultValid), 32'd0);

    // Randomized traffic: every opcode value, random gaps, starts while busy.
    ops = '{OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND, OP_MUL, OP_INCREMENT,
            OP_LSHIFT, OP_DECREMENT, OP_RSHIFT, 0};
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 3) == 0) op = $urandom_range(0, 15);
      else op = ops[$urandom_range(0, 10)];
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 9) < 7) begin
        drive(op, a, b);
        if (ready === 1'b1) exp_q.push_back(model(op, a, b));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 30) begin
      cnt++;
      @(negedge clock);
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    // Make the held result non-trivial, then reset in the middle of a MUL.
    single_op(OP_SUB, 8'h05, 8'h06);
    @(negedge clock);
    drive(OP_MUL, 8'h0F, 8'h0F);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_busy", 32'(ready), 32'd0);
    resetN = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("abort_no_valid", 32'(resultValid), 32'd0);
    end
    check_reset_outputs("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
